// File: rtl/fetch_unit_pkg.sv
// Shared ISA definitions for the fetch/decode/flow-control slice: opcodes,
// instruction width and the opcode field accessor.
package fetch_unit_pkg;

   localparam int unsigned INSTR_W = 16;

   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_LIX  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: word address out, same-cycle
// combinational read data back.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit_predecode.sv
// Combinational predecode of the ID word into the flags flow control needs.
module fetch_predecode
   import fetch_unit_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output logic               is_extended,
   output logic               is_control,
   output logic               is_halt
);

   always_comb begin
      is_extended = 1'b0;
      is_control  = 1'b0;
      is_halt     = 1'b0;
      case (opcode_of(instr))
         OP_BR, OP_JMP: is_control  = 1'b1;
         OP_LIX:        is_extended = 1'b1;
         OP_HALT:       is_halt     = 1'b1;
         default:       ;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: PC, redirect, extension-word capture and halt.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
   input  logic                clk,
   input  logic                reset,
   fetch_unit_if.master        imem,
   input  logic                stall_if,
   input  logic                stall_id,
   input  logic                squash_if,
   input  logic                squash_id,
   input  logic                extended_ld,
   input  logic                halt,
   input  logic                redirect_en,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic [INSTR_W-1:0]  id_instr,
   output logic [ADDR_W-1:0]   id_pc,
   output logic                id_valid,
   output logic [INSTR_W-1:0]  id_ext_imm,
   output logic                id_is_extended,
   output logic                id_is_control,
   output logic                id_is_halt,
   output logic                fetch_halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetches,
   output logic [15:0]         perf_redirects
`endif
);

   logic [ADDR_W-1:0] pc;
   logic              id_valid_q;
   logic              imm_slot;
   logic              halted;
   logic              pd_extended, pd_control, pd_halt;
   logic              flag_gate;
   logic              load_bubble;
   logic              load_fetch;

   fetch_predecode u_predecode (
      .instr       (id_instr),
      .is_extended (pd_extended),
      .is_control  (pd_control),
      .is_halt     (pd_halt)
   );

   // Extension words sitting in ID must never be decoded as instructions.
   assign flag_gate      = id_valid_q & ~imm_slot;
   assign id_is_extended = pd_extended & flag_gate;
   assign id_is_control  = pd_control  & flag_gate;
   assign id_is_halt     = pd_halt     & flag_gate;

   assign imem.imem_addr = pc;
   assign id_valid       = id_valid_q & ~squash_id;
   assign fetch_halted   = halted;

   assign load_bubble = halted | (~stall_id & squash_if);
   assign load_fetch  = ~halted & ~stall_id & ~squash_if;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         id_instr   <= NOP_WORD;
         id_pc      <= '0;
         id_valid_q <= 1'b0;
         imm_slot   <= 1'b0;
         id_ext_imm <= '0;
         halted     <= 1'b0;
      end else begin
         if (extended_ld)
            id_ext_imm <= id_instr;
         if (halt)
            halted <= 1'b1;

         if (!halted) begin
            if (redirect_en)
               pc <= redirect_pc;
            else if (!stall_if)
               pc <= pc + ADDR_W'(1);
         end

         if (load_bubble) begin
            id_instr   <= NOP_WORD;
            id_valid_q <= 1'b0;
            imm_slot   <= 1'b0;
         end else if (load_fetch) begin
            id_instr   <= imem.imem_rdata;
            id_pc      <= pc;
            id_valid_q <= 1'b1;
            imm_slot   <= id_is_extended;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetches   <= '0;
         perf_redirects <= '0;
      end else begin
         if (load_fetch && perf_fetches != '1)
            perf_fetches <= perf_fetches + 32'd1;
         if (redirect_en && perf_redirects != '1)
            perf_redirects <= perf_redirects + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios plus randomized
// flow-control stimulus checked against a behavioural pipeline model.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall_if, stall_id, squash_if, squash_id;
   logic        extended_ld, halt, redirect_en;
   logic [15:0] redirect_pc;
   logic [15:0] id_instr, id_pc, id_ext_imm;
   logic        id_valid, id_is_extended, id_is_control, id_is_halt, fetch_halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetches;
   logic [15:0] perf_redirects;
`endif

   logic [15:0] mem [0:65535];

   fetch_unit_if #(.ADDR_W(16)) bus ();
   assign bus.imem_rdata = mem[bus.imem_addr];

   fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem           (bus),
      .stall_if       (stall_if),
      .stall_id       (stall_id),
      .squash_if      (squash_if),
      .squash_id      (squash_id),
      .extended_ld    (extended_ld),
      .halt           (halt),
      .redirect_en    (redirect_en),
      .redirect_pc    (redirect_pc),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_valid       (id_valid),
      .id_ext_imm     (id_ext_imm),
      .id_is_extended (id_is_extended),
      .id_is_control  (id_is_control),
      .id_is_halt     (id_is_halt),
      .fetch_halted   (fetch_halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetches   (perf_fetches),
      .perf_redirects (perf_redirects)
`endif
   );

   typedef struct {
      logic        rst, sif, sid, qif, qid, ext, hlt, red;
      logic [15:0] rpc;
   } ctl_t;

   typedef struct {
      bit          skip;
      logic [15:0] addr, instr, pc, ext;
      logic        valid, vq, isx, isc, ish, hlt;
   } exp_t;

   exp_t exp_q[$];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
   endtask

   // Reference model: what the IF stage and ID slot hold, in plain terms.
   bit          m_init = 0;
   logic [15:0] m_pc, m_id, m_idpc, m_ext;
   logic        m_vq, m_is_imm, m_halted;
   int unsigned m_fetches, m_redirects;

   function automatic logic [2:0] kind(input logic [15:0] w);
      logic [3:0] op;
      op = w[15:12];
      return {op == 4'hE, op == 4'hC || op == 4'hD, op == 4'hF};
   endfunction

   function automatic logic [2:0] visible_kind();
      return (m_vq && !m_is_imm) ? kind(m_id) : 3'b000;
   endfunction

   function automatic void model_edge();
      logic [15:0] fetched;
      logic        was_halted, id_was_ext;
      if (reset) begin
         m_init = 1; m_pc = 16'h0000; m_id = 16'h0000; m_idpc = 16'h0000;
         m_ext = 16'h0000; m_vq = 0; m_is_imm = 0; m_halted = 0;
         m_fetches = 0; m_redirects = 0;
         return;
      end
      fetched    = mem[m_pc];
      was_halted = m_halted;
      id_was_ext = visible_kind()[2];
      if (extended_ld) m_ext = m_id;
      if (redirect_en) m_redirects++;
      if (halt) m_halted = 1;
      if (was_halted || (!stall_id && squash_if)) begin
         m_id = 16'h0000; m_vq = 0; m_is_imm = 0;
      end else if (!stall_id) begin
         m_id = fetched; m_idpc = m_pc; m_vq = 1; m_is_imm = id_was_ext;
         m_fetches++;
      end
      if (!was_halted) begin
         if (redirect_en) m_pc = redirect_pc;
         else if (!stall_if) m_pc = m_pc + 16'd1;
      end
   endfunction

   function automatic ctl_t idle();
      ctl_t c;
      c = '{default: '0};
      return c;
   endfunction

   function automatic ctl_t rand_ctl();
      ctl_t c;
      c.rst = ($urandom_range(0, 79) == 0);
      c.hlt = ($urandom_range(0, 149) == 0);
      c.red = ($urandom_range(0, 9) == 0);
      c.sif = ($urandom_range(0, 5) == 0);
      c.sid = ($urandom_range(0, 5) == 0);
      c.qif = ($urandom_range(0, 7) == 0);
      c.qid = ($urandom_range(0, 7) == 0);
      c.ext = ($urandom_range(0, 5) == 0);
      c.rpc = 16'($urandom);
      return c;
   endfunction

   // Apply controls, queue the expected outputs for this cycle, then take the edge.
   task automatic cyc(input ctl_t c);
      exp_t e;
      logic [2:0] k;
      reset = c.rst; stall_if = c.sif; stall_id = c.sid; squash_if = c.qif;
      squash_id = c.qid; extended_ld = c.ext; halt = c.hlt;
      redirect_en = c.red; redirect_pc = c.rpc;
      k = visible_kind();
      e.skip  = !m_init;
      e.addr  = m_pc;   e.instr = m_id; e.pc = m_idpc; e.ext = m_ext;
      e.vq    = m_vq;   e.valid = m_vq && !c.qid;
      e.isx   = k[2];   e.isc = k[1]; e.ish = k[0]; e.hlt = m_halted;
      exp_q.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      ctl_t c;
      c = idle(); c.rst = 1;
      cyc(c); cyc(c);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.skip) begin
               chk("imem_addr",      32'(bus.imem_addr), 32'(e.addr));
               chk("id_instr",       32'(id_instr),      32'(e.instr));
               chk("id_valid",       32'(id_valid),      32'(e.valid));
               chk("id_ext_imm",     32'(id_ext_imm),    32'(e.ext));
               chk("id_is_extended", 32'(id_is_extended), 32'(e.isx));
               chk("id_is_control",  32'(id_is_control), 32'(e.isc));
               chk("id_is_halt",     32'(id_is_halt),    32'(e.ish));
               chk("fetch_halted",   32'(fetch_halted),  32'(e.hlt));
               if (e.vq) chk("id_pc", 32'(id_pc), 32'(e.pc));
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      ctl_t c;
      reset = 1; stall_if = 0; stall_id = 0; squash_if = 0; squash_id = 0;
      extended_ld = 0; halt = 0; redirect_en = 0; redirect_pc = '0;
      for (int unsigned i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
      @(posedge clk); #1;

      // Straight-line fetch after reset, then a 3-cycle stall at pc=5.
      do_reset();
      chk("rst_addr",   32'(bus.imem_addr), 32'h0);
      chk("rst_valid",  32'(id_valid),      32'h0);
      chk("rst_instr",  32'(id_instr),      32'h0);
      chk("rst_halted", 32'(fetch_halted),  32'h0);
      chk("rst_ext",    32'(id_ext_imm),    32'h0);
      cyc(idle());
      chk("seq_addr1",  32'(bus.imem_addr), 32'h1);
      chk("seq_instr1", 32'(id_instr),      32'h1000);
      chk("seq_valid1", 32'(id_valid),      32'h1);
      cyc(idle());
      chk("seq_addr2",  32'(bus.imem_addr), 32'h2);
      chk("seq_instr2", 32'(id_instr),      32'h1001);
      repeat (3) cyc(idle());
      c = idle(); c.sif = 1; c.sid = 1;
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(c);
         chk("stall_addr",  32'(bus.imem_addr), 32'h5);
         chk("stall_instr", 32'(id_instr),      32'h1004);
         chk("stall_pc",    32'(id_pc),         32'h4);
      end
      cyc(idle());
      chk("resume_addr",  32'(bus.imem_addr), 32'h6);
      chk("resume_instr", 32'(id_instr),      32'h1005);

      // Taken branch in ID: redirect with the wrong-path fetch squashed.
      mem[3] = 16'hC010;
      do_reset();
      repeat (4) cyc(idle());
      chk("br_control", 32'(id_is_control), 32'h1);
      c = idle(); c.red = 1; c.rpc = 16'h0040; c.qif = 1;
      cyc(c);
      chk("br_addr",   32'(bus.imem_addr), 32'h40);
      chk("br_bubble", 32'(id_valid),      32'h0);
      chk("br_nop",    32'(id_instr),      32'h0);
      cyc(idle());
      chk("br_target_instr", 32'(id_instr), 32'h1040);
      chk("br_target_pc",    32'(id_pc),    32'h40);
      mem[3] = 16'h1003;

      // Extension word capture.
      mem[8] = 16'hE200; mem[9] = 16'hBEEF;
      do_reset();
      repeat (9) cyc(idle());
      chk("lix_ext", 32'(id_is_extended), 32'h1);
      cyc(idle());
      chk("imm_instr", 32'(id_instr),       32'hBEEF);
      chk("imm_ext",   32'(id_is_extended), 32'h0);
      c = idle(); c.ext = 1;
      cyc(c);
      chk("imm_capture", 32'(id_ext_imm), 32'hBEEF);

      // Halt freeze until reset.
      mem[4] = 16'hF000;
      do_reset();
      repeat (5) cyc(idle());
      chk("halt_flag", 32'(id_is_halt), 32'h1);
      c = idle(); c.hlt = 1;
      cyc(c);
      chk("halted_set",  32'(fetch_halted),  32'h1);
      chk("halted_addr", 32'(bus.imem_addr), 32'h6);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(idle());
         chk("frozen_addr",  32'(bus.imem_addr), 32'h6);
         chk("frozen_valid", 32'(id_valid),      32'h0);
         chk("frozen_halt",  32'(fetch_halted),  32'h1);
      end
      c = idle(); c.rst = 1;
      cyc(c);
      chk("unhalt_addr", 32'(bus.imem_addr), 32'h0);
      chk("unhalt_flag", 32'(fetch_halted),  32'h0);
      mem[4] = 16'h1004;

`ifdef FETCH_PERF_CNT_EN
      do_reset();
      repeat (10) cyc(idle());
      c = idle(); c.red = 1; c.sid = 1; c.rpc = 16'h0020;
      cyc(c);
      c.rpc = 16'h0030;
      cyc(c);
      chk("perf_fetches",   perf_fetches,          32'(m_fetches));
      chk("perf_fetches10", perf_fetches,          32'd10);
      chk("perf_redirects", 32'(perf_redirects),   32'd2);
`endif

      // Randomized program and flow-control traffic.
      for (int unsigned i = 0; i < 65536; i++) begin
         case ($urandom_range(0, 7))
            0:       mem[i] = 16'h0000;
            1:       mem[i] = {4'hC, 12'($urandom)};
            2:       mem[i] = {4'hD, 12'($urandom)};
            3:       mem[i] = {4'hE, 12'($urandom)};
            4:       mem[i] = {4'hF, 12'($urandom)};
            default: mem[i] = 16'($urandom);
         endcase
      end
      do_reset();
      for (int unsigned i = 0; i < 3000; i++) begin
         cyc(rand_ctl());
`ifdef FETCH_PERF_CNT_EN
         if (!reset) chk("perf_fetches_rand", perf_fetches, 32'(m_fetches));
`endif
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
